// File: rtl/and16b_rd_pkg.sv
// Shared types and constants for the adiabatic AND-array result reader.
// Power-clock phase encoding plus the default datapath width.
package and16b_rd_pkg;

    localparam int WIDTH_DEFAULT = 16;

    localparam logic [1:0] PH_EVAL    = 2'd0;
    localparam logic [1:0] PH_HOLD    = 2'd1;
    localparam logic [1:0] PH_RECOVER = 2'd2;
    localparam logic [1:0] PH_WAIT    = 2'd3;

    typedef enum logic [1:0] {
        EVAL    = PH_EVAL,
        HOLD    = PH_HOLD,
        RECOVER = PH_RECOVER,
        WAIT    = PH_WAIT
    } phase_e;

    // The power clock always walks EVAL -> HOLD -> RECOVER -> WAIT -> EVAL.
    function automatic phase_e phase_advance(input phase_e p);
        return phase_e'(p + 2'd1);
    endfunction

endpackage

// File: rtl/and16b_rd_fifo.sv
// Small first-word-fall-through FIFO buffering captured array results.
// Head word is registered; a push into an empty FIFO becomes visible one clock later.
module and16b_rd_fifo
    import and16b_rd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && (count_reg != CW'(DEPTH));

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Head register tracks the word at the next read pointer; when that word is
    // the one being written this clock, take it straight from push_data.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (count_next != '0) begin
                head_reg <= (do_push && (wr_ptr_reg == rd_ptr_next)) ? push_data
                                                                      : mem[rd_ptr_next];
            end
        end
    end

    assign head_data = head_reg;
    assign count     = count_reg;

endmodule

// File: rtl/and16b_result_reader.sv
// Reader for the adiabatic 16-bit AND array: phase tracking, slot pipeline, result FIFO.
// Optional operand self-check enabled by defining AND16B_RESULT_CHECK_EN.
module and16b_result_reader
    import and16b_rd_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter int DEPTH    = 4,
    parameter int PIPE_LAT = 1
) (
    input  logic                   clkpos,
    input  logic                   rst,
    input  logic                   phase_sync,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [WIDTH-1:0]       issue_a,
    input  logic [WIDTH-1:0]       issue_b,
    input  logic [WIDTH-1:0]       res_in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   chk_err
);

    phase_e                  phase_reg;
    phase_e                  phase_now;
    phase_e                  phase_next;
    logic                    is_eval;
    logic                    is_hold;
    logic                    credit_ok;
    logic                    fire;
    logic                    capture;
    logic [31:0]             inflight;
    logic [PIPE_LAT:0]       sr_reg;
    logic [PIPE_LAT:0]       sr_next;
    logic [$clog2(DEPTH):0]  fifo_count;

    // Phase FSM: state register.
    always_ff @(posedge clkpos) begin
        if (rst) begin
            phase_reg <= EVAL;
        end else begin
            phase_reg <= phase_next;
        end
    end

    // Phase FSM: next state. phase_sync forces EVAL regardless of where we are.
    always_comb begin
        phase_now  = phase_sync ? EVAL : phase_reg;
        phase_next = phase_advance(phase_now);
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= PIPE_LAT; i++) begin
            inflight = inflight + 32'(sr_reg[i]);
        end
    end

    // Credit counts in-flight slots too, so a capture can never find the FIFO full.
    assign credit_ok = (inflight + 32'(fifo_count)) < 32'(DEPTH);

    // Phase FSM: outputs.
    always_comb begin
        is_eval     = (phase_now == EVAL);
        is_hold     = (phase_now == HOLD);
        issue_ready = !rst && is_eval && credit_ok;
        capture     = is_hold && sr_reg[PIPE_LAT];
    end

    assign fire = issue_valid && issue_ready;

    genvar gi;
    generate
        for (gi = 0; gi <= PIPE_LAT; gi++) begin : g_slot
            logic shift_in;
            if (gi == 0) begin : g_head
                assign shift_in = fire;
            end else begin : g_tail
                assign shift_in = sr_reg[gi-1];
            end
            if (gi == PIPE_LAT) begin : g_last
                assign sr_next[gi] = is_eval ? shift_in : (sr_reg[gi] && !capture);
            end else begin : g_mid
                assign sr_next[gi] = is_eval ? shift_in : sr_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clkpos) begin
        if (rst) begin
            sr_reg <= '0;
        end else begin
            sr_reg <= sr_next;
        end
    end

`ifdef AND16B_RESULT_CHECK_EN
    logic [WIDTH-1:0] opnd_reg  [PIPE_LAT+1];
    logic [WIDTH-1:0] opnd_next [PIPE_LAT+1];
    logic             chk_err_reg;

    // Expected array output rides alongside each slot bit.
    generate
        for (gi = 0; gi <= PIPE_LAT; gi++) begin : g_opnd
            if (gi == 0) begin : g_head
                assign opnd_next[gi] = issue_a & issue_b;
            end else begin : g_tail
                assign opnd_next[gi] = opnd_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clkpos) begin
        if (is_eval) begin
            for (int i = 0; i <= PIPE_LAT; i++) begin
                opnd_reg[i] <= opnd_next[i];
            end
        end
    end

    always_ff @(posedge clkpos) begin
        if (rst) begin
            chk_err_reg <= 1'b0;
        end else if (capture && (res_in != opnd_reg[PIPE_LAT])) begin
            chk_err_reg <= 1'b1;
        end
    end

    assign chk_err = chk_err_reg;
`else
    logic unused_operands;
    assign unused_operands = ^{issue_a, issue_b};
    assign chk_err         = 1'b0;
`endif

    and16b_rd_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clkpos),
        .srst      (rst),
        .push      (capture),
        .push_data (res_in),
        .pop       (m_valid && m_ready),
        .head_data (m_data),
        .count     (fifo_count)
    );

    assign m_valid = (fifo_count != '0);
    assign count   = fifo_count;

endmodule

// File: tb/tb_and16b_result_reader.sv
// Self-checking bench for and16b_result_reader (WIDTH=16, DEPTH=4, PIPE_LAT=1).
// A phase/slot model drives res_in only at the expected capture cycle and scoreboards results.
module tb_and16b_result_reader;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int PL = 1;
`ifdef AND16B_RESULT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clkpos = 1'b0;
    logic          rst;
    logic          phase_sync;
    logic          issue_valid;
    logic          issue_ready;
    logic [W-1:0]  issue_a;
    logic [W-1:0]  issue_b;
    logic [W-1:0]  res_in;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [2:0]    count;
    logic          chk_err;

    always #5 clkpos = ~clkpos;

    and16b_result_reader #(.WIDTH(W), .DEPTH(D), .PIPE_LAT(PL)) dut (
        .clkpos      (clkpos),
        .rst         (rst),
        .phase_sync  (phase_sync),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .res_in      (res_in),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .count       (count),
        .chk_err     (chk_err)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state.
    int           ph_q = 0;
    bit           sv [0:PL];
    logic [W-1:0] sd [0:PL];
    logic [W-1:0] sbq [$];
    bit           m_chk = 1'b0;
    bit           ovr_en = 1'b0;
    logic [W-1:0] ovr_val = '0;

    logic         obs_ready, obs_valid, obs_chk;
    logic [W-1:0] obs_data;
    logic [2:0]   obs_count;

    typedef struct {
        bit           s;
        bit           iv;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           mr;
        bit           exp_rdy;
        bit           exp_vld;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t vt [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model after posedge.
    task automatic cycle(input bit r, input bit s, input bit iv,
                         input logic [W-1:0] a, input logic [W-1:0] b, input bit mr);
        int           ph_now;
        int           credit;
        bit           exp_rdy;
        bit           cap;
        logic [W-1:0] rv;
        logic [W-1:0] popped;
        rst = r; phase_sync = s; issue_valid = iv; issue_a = a; issue_b = b; m_ready = mr;
        ph_now = s ? 0 : ph_q;
        credit = sbq.size();
        for (int i = 0; i <= PL; i++) credit += int'(sv[i]);
        exp_rdy = !r && (ph_now == 0) && (credit < D);
        cap     = !r && (ph_now == 1) && sv[PL];
        rv      = cap ? (ovr_en ? ovr_val : sd[PL]) : W'($urandom);
        res_in  = rv;
        @(negedge clkpos);
        obs_ready = issue_ready; obs_valid = m_valid; obs_data = m_data;
        obs_count = count; obs_chk = chk_err;
        check("issue_ready", 32'(issue_ready), 32'(exp_rdy));
        check("m_valid", 32'(m_valid), 32'(sbq.size() != 0));
        check("count", 32'(count), 32'(sbq.size()));
        if (sbq.size() != 0) check("m_data", 32'(m_data), 32'(sbq[0]));
        check("chk_err", 32'(chk_err), 32'(m_chk));
        @(posedge clkpos);
        #1;
        if (r) begin
            ph_q = 0;
            for (int i = 0; i <= PL; i++) sv[i] = 1'b0;
            sbq.delete();
            m_chk = 1'b0;
        end else begin
            if ((sbq.size() != 0) && mr) begin
                popped = sbq.pop_front();
                $display("pop data=%h", popped);
            end
            if (cap) begin
                sbq.push_back(rv);
                if (CHK_EN && (rv != sd[PL])) m_chk = 1'b1;
                sv[PL] = 1'b0;
            end
            if (ph_now == 0) begin
                for (int i = PL; i > 0; i--) begin
                    sv[i] = sv[i-1];
                    sd[i] = sd[i-1];
                end
                sv[0] = exp_rdy && iv;
                sd[0] = a & b;
            end
            ph_q = (ph_now + 1) % 4;
        end
    endtask

    task automatic idle(input bit mr);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, mr);
    endtask

    task automatic to_eval(input bit mr);
        for (int i = 0; i < 4 && ph_q != 0; i++) idle(mr);
    endtask

    initial begin
        bit seen_valid;
        for (int i = 0; i <= PL; i++) begin sv[i] = 1'b0; sd[i] = '0; end
        rst = 1'b1; phase_sync = 1'b0; issue_valid = 1'b0; issue_a = '0; issue_b = '0;
        res_in = '0; m_ready = 1'b0;
        repeat (2) @(posedge clkpos);
        @(negedge clkpos);
        check("rst_issue_ready", 32'(issue_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_chk_err", 32'(chk_err), 32'd0);
        @(posedge clkpos);
        #1;

        // Basic path and phase gating, expectations derived by hand.
        for (int i = 0; i < 20; i++) begin
            vt[i] = '{s: 1'b0, iv: 1'b0, a: '0, b: '0, mr: 1'b1,
                      exp_rdy: (i % 4) == 0, exp_vld: 1'b0, exp_data: '0};
        end
        vt[0].s = 1'b1; vt[0].iv = 1'b1; vt[0].a = 16'hFFFF; vt[0].b = 16'h00FF;
        for (int i = 8; i < 12; i++) begin
            vt[i].iv = 1'b1; vt[i].a = 16'h1234; vt[i].b = 16'h0FF0;
        end
        vt[12].iv = 1'b1; vt[12].a = 16'hF0F0; vt[12].b = 16'hFF00;
        vt[6].exp_vld  = 1'b1; vt[6].exp_data  = 16'h00FF;
        vt[14].exp_vld = 1'b1; vt[14].exp_data = 16'h0230;
        vt[18].exp_vld = 1'b1; vt[18].exp_data = 16'hF000;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, vt[i].s, vt[i].iv, vt[i].a, vt[i].b, vt[i].mr);
            check("tbl_ready", 32'(obs_ready), 32'(vt[i].exp_rdy));
            check("tbl_valid", 32'(obs_valid), 32'(vt[i].exp_vld));
            if (vt[i].exp_vld) check("tbl_data", 32'(obs_data), 32'(vt[i].exp_data));
        end

        // Credit and full.
        to_eval(1'b1);
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] av;
            av = 16'h1111 * 16'(k + 1);
            cycle(1'b0, 1'b0, 1'b1, av, 16'hFFFF, 1'b0);
            check("t3_issue_ready", 32'(obs_ready), 32'd1);
            repeat (3) idle(1'b0);
        end
        cycle(1'b0, 1'b0, 1'b1, 16'hABCD, 16'hFFFF, 1'b0);
        check("t3_full_ready", 32'(obs_ready), 32'd0);
        idle(1'b0);
        idle(1'b0);
        check("t3_count_full", 32'(obs_count), 32'd4);
        idle(1'b1);
        idle(1'b0);
        check("t3_ready_after_pop", 32'(obs_ready), 32'd1);
        repeat (6) idle(1'b1);

        // Resync with one slot in flight.
        to_eval(1'b1);
        cycle(1'b0, 1'b0, 1'b1, 16'h0F0F, 16'h00FF, 1'b1);
        idle(1'b1);
        cycle(1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
        check("t4_sync_ready", 32'(obs_ready), 32'd1);
        idle(1'b1);
        check("t4_no_early_valid", 32'(obs_valid), 32'd0);
        idle(1'b1);
        check("t4_valid", 32'(obs_valid), 32'd1);
        check("t4_data", 32'(obs_data), 32'h000F);
        repeat (4) idle(1'b1);

        // Self-check mismatch, stickiness, clear on reset.
        to_eval(1'b1);
        ovr_en = 1'b1; ovr_val = 16'h1234;
        cycle(1'b0, 1'b0, 1'b1, 16'h1234, 16'hFFF0, 1'b1);
        repeat (4) idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        ovr_en = 1'b0;
        check("t5_chk_set", 32'(obs_chk), 32'(CHK_EN));
        check("t5_data", 32'(obs_data), 32'h1234);
        to_eval(1'b1);
        cycle(1'b0, 1'b0, 1'b1, 16'h00FF, 16'h0F0F, 1'b1);
        repeat (8) idle(1'b1);
        check("t5_chk_sticky", 32'(obs_chk), 32'(CHK_EN));
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(1'b1);
        check("t5_chk_cleared", 32'(obs_chk), 32'd0);
        repeat (4) idle(1'b1);

        // Reset with two slots in flight and one buffered.
        to_eval(1'b0);
        cycle(1'b0, 1'b0, 1'b1, 16'h00F0, 16'h0FF0, 1'b0);
        repeat (3) idle(1'b0);
        cycle(1'b0, 1'b0, 1'b1, 16'h5555, 16'hFFFF, 1'b0);
        repeat (3) idle(1'b0);
        cycle(1'b0, 1'b0, 1'b1, 16'hAAAA, 16'hFFFF, 1'b0);
        check("t6_buffered", 32'(obs_count), 32'd1);
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(1'b1);
        check("t6_count", 32'(obs_count), 32'd0);
        check("t6_valid", 32'(obs_valid), 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            idle(1'b1);
            if (obs_valid) seen_valid = 1'b1;
        end
        check("t6_no_valid", 32'(seen_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/and16b_result_reader.md
Name: and16b_result_reader

Overview:
- Static-logic reader at the output end of the adiabatic 16-bit AND array.
- Tracks the four-phase power-clock cycle: EVAL, HOLD, RECOVER, WAIT.
- Issues operand slots only in EVAL and samples the array output only in its HOLD phase.
- Buffers captured results in a small FIFO behind a valid/ready interface for the synchronous MIPS25 datapath.

Parameters:
- WIDTH, 16, result/operand width.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- PIPE_LAT, 1, power-clock cycles from issue to result hold (0..3).

Ports:
- clkpos  in  1  clock, aligned to the positive power clock.
- rst  in  1  reset.
- phase_sync  in  1  pulse marking the current cycle as EVAL.
- issue_valid  in  1  operand pair presented to the array.
- issue_ready  out  1  issue accepted this cycle.
- issue_a  in  WIDTH  operand a.
- issue_b  in  WIDTH  operand b.
- res_in  in  WIDTH  array output (out[15:0] of the AND array).
- m_valid  out  1  result available.
- m_ready  in  1  downstream accepts.
- m_data  out  WIDTH  result.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- chk_err  out  1  sticky self-check mismatch.

Behaviour:
- Single clock clkpos; reset rst is synchronous, active-high.
- Reset values: phase=EVAL(0), slot shift register cleared, FIFO empty, m_valid=0, m_data=0, count=0, chk_err=0, issue_ready=0 during reset.
- Phase: phase_now = phase_sync ? EVAL : phase_q; phase_q <= phase_now+1 mod 4.
  - Encoding: EVAL=0, HOLD=1, RECOVER=2, WAIT=3.
  - phase_sync in any phase restarts at EVAL; in-flight slots are kept.
- Credit: issue_ready = (phase_now==EVAL) && (inflight + count < DEPTH).
  - inflight = number of set slot bits.
  - Guarantees no FIFO overflow, so overflow handling is unnecessary.
- Slot register sr[0..PIPE_LAT]:
  - Shifts only when phase_now==EVAL: sr[0] <= issue_valid && issue_ready; sr[k] <= sr[k-1].
  - issue_valid outside EVAL is ignored, with no side effect.
- Capture: when phase_now==HOLD and sr[PIPE_LAT]=1, push res_in into the FIFO and clear that slot bit.
  - res_in in any other phase is never sampled.
- Latency:
  - Capture occurs 4*PIPE_LAT+1 clocks after the issue cycle.
  - m_valid rises the following clock, i.e. 4*PIPE_LAT+2 clocks after issue.
  - With no phase_sync in between, PIPE_LAT=1 gives 6 clocks.
- FIFO:
  - First-word-fall-through on m_data; pop on m_valid && m_ready.
  - Simultaneous push/pop: count unchanged, order preserved.
  - Push into an empty FIFO has no same-cycle bypass.
  - Read/write pointers wrap mod DEPTH.
- m_data holds its last value when empty; it is not cleared.
- Reset mid-operation discards all in-flight slots and buffered results; no m_valid pulse follows.

Optional Feature:
- Macro: AND16B_RESULT_CHECK_EN.
- Defined:
  - Each slot also carries issue_a & issue_b.
  - At capture, if res_in differs from the stored value, chk_err is set and stays set until rst.
  - Data is pushed regardless of a mismatch.
- Undefined:
  - No operand storage; chk_err is tied 0.
  - issue_a and issue_b remain as ports but are unused.

Decomposition:
- Package and16b_rd_pkg holds:
  - phase_e enum (EVAL, HOLD, RECOVER, WAIT).
  - WIDTH_DEFAULT=16.
  - Phase encoding constants.
- Sub-module and16b_rd_fifo: synchronous FIFO parameterised by WIDTH and DEPTH, exposing push, pop, count, head data.
- Phase counter, slot register and checker stay in the top module.

Test Plan:
1. Basic path (PIPE_LAT=1):
   - Stimulus: rst, then phase_sync at T0; issue a=FFFF b=00FF at T0; res_in=00FF during HOLD at T5, garbage otherwise; m_ready=1.
   - Response: m_valid=1 with m_data=00FF at T6 only.
2. Phase gating:
   - Stimulus: issue_valid held through HOLD, RECOVER and WAIT.
   - Response: issue_ready=0 in those phases; exactly one slot accepted per EVAL.
3. Credit and full:
   - Stimulus: m_ready=0; issue on 4 consecutive EVALs.
   - Response: count reaches 4; issue_ready=0 at the 5th EVAL. Pop once, and issue_ready=1 at the next EVAL.
4. Resync:
   - Stimulus: phase_sync asserted while phase_q=2 with one slot in flight.
   - Response: that cycle is EVAL, the slot advances, and capture follows the new HOLD alignment.
5. Self-check (AND16B_RESULT_CHECK_EN defined):
   - Stimulus: a&b=1230, res_in=1234 at capture.
   - Response: chk_err=1 next cycle, m_data=1234. chk_err stays 1 after a matching transaction and clears only on rst.
6. Reset mid-flight:
   - Stimulus: 2 slots in flight and 1 buffered; assert rst one cycle.
   - Response: count=0, m_valid=0, and no later m_valid without a new issue.
